inst_line_fill: RTL and testbench
=================================

// Module: inst_line_fill
// PURPOSE
//  Instruction-RAM line-fill engine: on a fetch miss, reads one 128-bit line (4x32b words)
//  from external memory over a split request/response bus, assembles it, and writes it into
//  the instruction RAM's 128-bit write port in one cycle. Sits between the IF-stage miss
//  logic and the instruction RAM. It is the writer for the RAM's wide write port.
// PARAMETERS
//  IWIDTH    14            instruction-RAM word-address width; line address is IWIDTH-2 bits
//  BASE_ADR  32'h0000_0000 external byte address of RAM line 0
// PORTS
//  clk            in   1         clock; all logic on posedge
//  rst            in   1         async reset, active-high
//  fill_req       in   1         start fill; sampled only in IDLE
//  fill_ladr      in   IWIDTH-2  line address to fill; latched with fill_req
//  fill_abort     in   1         cancel in-flight fill (pipeline flush)
//  fill_busy      out  1         high in any state except IDLE
//  fill_done      out  1         1-cycle pulse: line written and readable
//  mem_req        out  1         word read request valid
//  mem_radr       out  32        request byte address
//  mem_ack        in   1         request accepted this cycle (mem_req & mem_ack = transfer)
//  mem_rvalid     in   1         response word valid; responses return in request order
//  mem_rdata      in   32        response data
//  ram_wadr_all   out  IWIDTH-2  RAM line write address
//  ram_wdata_all  out  128       {w3,w2,w1,w0}; w0 = lowest word address
//  ram_wen_all    out  1         RAM line write enable, 1 cycle
// BEHAVIOUR
//  Reset: state IDLE; fill_busy, fill_done, mem_req, ram_wen_all = 0; counters, latched
//   address, line buffer = 0; mem_radr, ram_wadr_all, ram_wdata_all = 0.
//  Counters: iss_cnt[2:0] = requests accepted, rsp_cnt[2:0] = responses taken; both 0..4.
//  IDLE : fill_req=1 -> latch fill_ladr, clear counters, -> REQ. fill_abort ignored.
//  REQ  : mem_req=1, mem_radr = BASE_ADR + {ladr, iss_cnt[1:0], 2'b00} (32-bit wrap).
//         mem_ack -> iss_cnt++; 4th ack -> WAIT (mem_req low next cycle).
//  WAIT : mem_req=0; wait for remaining responses.
//  In REQ/WAIT each mem_rvalid writes mem_rdata into word slot rsp_cnt[1:0], rsp_cnt++;
//   rvalid may coincide with ack, including in the first REQ cycle.
//   4th response -> WRITE next cycle (from REQ or WAIT).
//  WRITE: ram_wen_all=1, ram_wadr_all=ladr, ram_wdata_all=buffer, exactly one cycle -> DONE.
//  DONE : fill_done=1 one cycle (RAM write has completed) -> IDLE; new fill_req taken
//         in the following IDLE cycle. Min latency, ack+rvalid next cycle: req sampled
//         at c0, acks c1-c4, rvalid c2-c5, WRITE c6, fill_done c7.
//  fill_abort in REQ/WAIT -> DRAIN next cycle; an ack in the abort cycle counts as issued.
//  DRAIN: mem_req=0; consume (discard) rvalid until rsp_cnt==iss_cnt -> IDLE.
//   No RAM write, no fill_done. If already equal on entry -> IDLE next cycle.
//  fill_abort in WRITE/DONE ignored: line completes normally.
//  mem_rvalid when rsp_cnt==iss_cnt (nothing outstanding) in any state: ignored.
//  Reset mid-fill: immediate return to IDLE, outputs to reset values; bus responses in
//   flight are the memory side's problem (it is reset by the same rst).
//  mem_radr/mem_req driven from registered state only; no comb path mem_ack->mem_req.
// STRUCTURE
//  Package inst_fill_pkg: state enum (IDLE,REQ,WAIT,WRITE,DONE,DRAIN), LINE_WORDS=4,
//   WORD_BITS=32.
//  Sub-module fill_line_buf: 4x32 register file, word-select write, 128-bit concat out.
//  FSM, counters, address generation in inst_line_fill.
// TESTING
//  1 ladr=0x005, BASE=0, ack always 1, rvalid 1 cycle later, data 0x11..0x44 -> mem_radr
//    0x50,0x54,0x58,0x5C; ram_wen_all at c6, wdata=0x00000044_00000033_00000022_00000011,
//    wadr=0x005, fill_done at c7.
//  2 Random ack/rvalid stalls (0-5 cycles) -> same line image, exactly one wen, one done,
//    never more than 4 acks per fill.
//  3 fill_abort after 2 acks, 1 response -> DRAIN until 2nd response, IDLE, no wen, no done;
//    next fill (ladr=0x006) correct with no stale words.
//  4 fill_abort same cycle as 4th rvalid / in WRITE -> abort ignored, line written, done.
//  5 Spurious mem_rvalid in IDLE, fill_req held high continuously -> spurious ignored;
//    back-to-back fills with exactly one IDLE cycle between fill_done and next REQ.
//  6 rst asserted in WAIT after 3 responses -> all outputs 0 same cycle, IDLE after release.

Source files
------------

// File: rtl/inst_fill_pkg.sv
// Purpose : shared types and constants for the instruction-RAM line-fill engine.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: fill FSM state enum, line geometry, external word address helper.
package inst_fill_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_BITS  = 32;
    localparam int LINE_BITS  = LINE_WORDS * WORD_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } fill_state_e;

    // External byte address of one word of a line; the add wraps at 32 bits.
    function automatic logic [31:0] line_word_adr(input logic [31:0] base,
                                                  input logic [31:0] ladr,
                                                  input logic [1:0]  word);
        return base + {ladr[27:0], word, 2'b00};
    endfunction

endpackage

// File: rtl/inst_line_fill_if.sv
// Purpose : groups the fill-control, memory request/response and RAM line-write signals.
// Latency : n/a (wiring only).
// Backpr. : memory request side uses mem_req/mem_ack; responses are not back-pressured.
// Modports: master = the fill engine, slave = miss logic / memory / RAM side.
interface inst_line_fill_if
    import inst_fill_pkg::*;
#(
    parameter int IWIDTH = 14
);
    // fill control
    logic                  fill_req;
    logic [IWIDTH-3:0]     fill_ladr;
    logic                  fill_abort;
    logic                  fill_busy;
    logic                  fill_done;
    // external memory, split request/response
    logic                  mem_req;
    logic [31:0]           mem_radr;
    logic                  mem_ack;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;
    // instruction RAM wide write port
    logic [IWIDTH-3:0]     ram_wadr_all;
    logic [LINE_BITS-1:0]  ram_wdata_all;
    logic                  ram_wen_all;

    modport master (
        input  fill_req, fill_ladr, fill_abort, mem_ack, mem_rvalid, mem_rdata,
        output fill_busy, fill_done, mem_req, mem_radr,
               ram_wadr_all, ram_wdata_all, ram_wen_all
    );

    modport slave (
        output fill_req, fill_ladr, fill_abort, mem_ack, mem_rvalid, mem_rdata,
        input  fill_busy, fill_done, mem_req, mem_radr,
               ram_wadr_all, ram_wdata_all, ram_wen_all
    );

endinterface

// File: rtl/fill_line_buf.sv
// Purpose : 4x32 line assembly buffer, one word written per cycle by slot index.
// Latency : write visible on line_o the cycle after wr_en_i.
// Backpr. : none; every write strobe is taken.
// Ports   : clk/rst, wr_en_i/wr_sel_i/wr_dat_i word write, line_o = {w3,w2,w1,w0}.
module fill_line_buf
    import inst_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [1:0]            wr_sel_i,
    input  logic [WORD_BITS-1:0]  wr_dat_i,
    output logic [LINE_BITS-1:0]  line_o
);

    logic [WORD_BITS-1:0] word_q [LINE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            word_q[wr_sel_i] <= wr_dat_i;
        end
    end

    // Word 0 (lowest address) sits in the least significant bits.
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_cat
        assign line_o[g*WORD_BITS +: WORD_BITS] = word_q[g];
    end

endmodule

// File: rtl/inst_line_fill.sv
// Purpose : on a fetch miss, reads a 4-word line from external memory and writes it to the
//           instruction RAM wide port in one cycle; supports abort with response drain.
// Latency : best case req sampled c0, RAM write c6, fill_done c7.
// Backpr. : requests held until mem_ack; responses never stalled, taken in request order.
// Ports   : clk, rst (async, active-high), bus (inst_line_fill_if.master).
module inst_line_fill
    import inst_fill_pkg::*;
#(
    parameter int          IWIDTH   = 14,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    inst_line_fill_if.master bus
);

    localparam int LW = IWIDTH - 2;

    fill_state_e          state_q, state_d;
    logic [2:0]           iss_cnt_q, iss_cnt_d;
    logic [2:0]           rsp_cnt_q, rsp_cnt_d;
    logic [LW-1:0]        ladr_q, ladr_d;
    logic [LINE_BITS-1:0] line;
    logic                 ack_xfer;
    logic                 rsp_take;
    logic                 buf_wen;

    // A response only counts while something is outstanding; anything else is stray.
    assign ack_xfer = (state_q == REQ) && bus.mem_ack;
    assign rsp_take = bus.mem_rvalid && (rsp_cnt_q != iss_cnt_q)
                      && ((state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN));
    // Drained responses are counted but never land in the line buffer.
    assign buf_wen  = rsp_take && (state_q != DRAIN);

    fill_line_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (buf_wen),
        .wr_sel_i (rsp_cnt_q[1:0]),
        .wr_dat_i (bus.mem_rdata),
        .line_o   (line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            iss_cnt_q <= '0;
            rsp_cnt_q <= '0;
            ladr_q    <= '0;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            ladr_q    <= ladr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ladr_d    = ladr_q;
        iss_cnt_d = 3'(iss_cnt_q + {2'b00, ack_xfer});
        rsp_cnt_d = 3'(rsp_cnt_q + {2'b00, rsp_take});
        case (state_q)
            IDLE: begin
                if (bus.fill_req) begin
                    ladr_d    = bus.fill_ladr;
                    iss_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = REQ;
                end
            end
            REQ, WAIT: begin
                // The last word arriving wins over a same-cycle abort.
                if (rsp_cnt_d == 3'd4) begin
                    state_d = WRITE;
                end else if (bus.fill_abort) begin
                    state_d = DRAIN;
                end else if ((state_q == REQ) && (iss_cnt_d == 3'd4)) begin
                    state_d = WAIT;
                end
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
            DRAIN: begin
                if (rsp_cnt_d == iss_cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode registered state, so reset clears them immediately and
    // there is no combinational path from mem_ack back to mem_req.
    assign bus.fill_busy     = (state_q != IDLE);
    assign bus.fill_done     = (state_q == DONE);
    assign bus.mem_req       = (state_q == REQ);
    assign bus.mem_radr      = (state_q == REQ)
                               ? line_word_adr(BASE_ADR, 32'(ladr_q), iss_cnt_q[1:0]) : '0;
    assign bus.ram_wen_all   = (state_q == WRITE);
    assign bus.ram_wadr_all  = (state_q == WRITE) ? ladr_q : '0;
    assign bus.ram_wdata_all = (state_q == WRITE) ? line : '0;

endmodule

// File: tb/tb_inst_line_fill.sv
// Purpose : scoreboard bench for inst_line_fill with a randomized in-order memory model.
// Latency : n/a.
// Backpr. : memory model inserts random ack and response stalls.
module tb_inst_line_fill;
    import inst_fill_pkg::*;

    localparam int          IWIDTH = 14;
    localparam int          LW     = IWIDTH - 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    typedef struct {
        logic [LW-1:0]  ladr;
        logic [127:0]   line;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_line_fill_if #(.IWIDTH(IWIDTH)) bus ();

    inst_line_fill #(.IWIDTH(IWIDTH), .BASE_ADR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int wen_cnt  = 0;
    int done_cnt = 0;

    logic [31:0] addr_q[$];
    line_t       line_q[$];
    logic [31:0] pend_q[$];

    int ack_mode      = 0;   // 0 always ack, 1 random stalls, 2 never
    int rsp_stall_max = 0;
    int ack_wait      = 0;
    int rsp_wait      = 0;
    bit spur_en       = 1'b0;
    int data_mode     = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur or was not expected", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_mode == 0) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] word_adr(input logic [LW-1:0] l, input int i);
        return BASE + 32'(l) * 32'd16 + 32'(i) * 32'd4;
    endfunction

    function automatic logic [127:0] exp_line(input logic [LW-1:0] l);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = mem_word(word_adr(l, i));
        return r;
    endfunction

    task automatic push_addrs(input logic [LW-1:0] l, input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(word_adr(l, i));
    endtask

    task automatic push_fill(input logic [LW-1:0] l);
        line_t e;
        push_addrs(l, 4);
        e.ladr = l;
        e.line = exp_line(l);
        line_q.push_back(e);
    endtask

    // Memory model: in-order responses, random ack/response stalls, optional stray rvalid.
    initial begin
        bit          xfer;
        bit          rtake;
        bit          real_rsp;
        logic [31:0] xadr;
        real_rsp = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            xfer  = !rst && bus.mem_req && bus.mem_ack;
            xadr  = bus.mem_radr;
            rtake = !rst && bus.mem_rvalid && real_rsp;
            @(posedge clk);
            #1;
            if (rst) begin
                pend_q.delete();
                bus.mem_ack    = 1'b0;
                bus.mem_rvalid = 1'b0;
                real_rsp       = 1'b0;
            end else begin
                if (rtake) begin
                    void'(pend_q.pop_front());
                    rsp_wait = $urandom_range(0, rsp_stall_max);
                end
                if (xfer) pend_q.push_back(xadr);
                case (ack_mode)
                    0: bus.mem_ack = 1'b1;
                    1: begin
                        if (ack_wait > 0) begin
                            bus.mem_ack = 1'b0;
                            ack_wait--;
                        end else begin
                            bus.mem_ack = 1'b1;
                            ack_wait = $urandom_range(0, 5);
                        end
                    end
                    default: bus.mem_ack = 1'b0;
                endcase
                real_rsp = 1'b0;
                if (pend_q.size() > 0) begin
                    if (rsp_wait > 0) begin
                        rsp_wait--;
                        bus.mem_rvalid = 1'b0;
                    end else begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = mem_word(pend_q[0]);
                        real_rsp       = 1'b1;
                    end
                end else if (spur_en && ($urandom_range(0, 1) == 1)) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hDEAD_BEEF;
                end else begin
                    bus.mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: request addresses, RAM line writes and the done pulse.
    initial begin
        logic  prev_wen;
        line_t e;
        prev_wen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_req && bus.mem_ack) begin
                    if (addr_q.size() == 0) fail_now("extra_ack");
                    else check("mem_radr", {96'd0, bus.mem_radr}, {96'd0, addr_q.pop_front()});
                end
                if (bus.ram_wen_all) begin
                    wen_cnt++;
                    if (line_q.size() == 0) begin
                        fail_now("unexpected_wen");
                    end else begin
                        e = line_q.pop_front();
                        check("ram_wadr_all", {116'd0, bus.ram_wadr_all}, {116'd0, e.ladr});
                        check("ram_wdata_all", bus.ram_wdata_all, e.line);
                    end
                end
                if (bus.fill_done) done_cnt++;
                if (bus.fill_done || prev_wen)
                    check("done_after_wen", {127'd0, bus.fill_done}, {127'd0, prev_wen});
                prev_wen = bus.ram_wen_all;
            end else begin
                prev_wen = 1'b0;
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fill_done && n < 300);
        if (!bus.fill_done) fail_now(name);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.fill_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.fill_busy) fail_now("idle_timeout");
    endtask

    // Starts a fill; the posedge after this call samples it (c0), returns at c0+1.
    task automatic issue(input logic [LW-1:0] l, input bit full);
        wait_idle();
        bus.fill_ladr = l;
        bus.fill_req  = 1'b1;
        if (full) push_fill(l);
        @(posedge clk);
        #1;
        bus.fill_req = 1'b0;
    endtask

    task automatic quiet_mem(input int mode, input int stall);
        ack_mode      = mode;
        rsp_stall_max = stall;
        ack_wait      = 0;
        rsp_wait      = 0;
    endtask

    initial begin
        logic [127:0] t1_line;
        logic [LW-1:0] l;
        int w0;
        int d0;
        t1_line = 128'h00000044_00000033_00000022_00000011;
        bus.fill_req   = 1'b0;
        bus.fill_ladr  = '0;
        bus.fill_abort = 1'b0;

        // Reset state
        #2;
        check("rst_busy",  {127'd0, bus.fill_busy},   128'd0);
        check("rst_done",  {127'd0, bus.fill_done},   128'd0);
        check("rst_req",   {127'd0, bus.mem_req},     128'd0);
        check("rst_wen",   {127'd0, bus.ram_wen_all}, 128'd0);
        check("rst_radr",  {96'd0, bus.mem_radr},     128'd0);
        check("rst_wdata", bus.ram_wdata_all,         128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: minimum-latency fill, exact cycle positions
        quiet_mem(0, 0);
        data_mode = 0;
        issue(12'h005, 1'b1);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 5) check("t1_no_wen_c5", {127'd0, bus.ram_wen_all}, 128'd0);
            if (n == 6) begin
                check("t1_wen_c6",   {127'd0, bus.ram_wen_all}, 128'd1);
                check("t1_wdata_c6", bus.ram_wdata_all, t1_line);
                check("t1_wadr_c6",  {116'd0, bus.ram_wadr_all}, 128'h5);
            end
            if (n == 7) check("t1_done_c7", {127'd0, bus.fill_done}, 128'd1);
        end
        @(negedge clk);
        check("t1_idle", {127'd0, bus.fill_busy}, 128'd0);

        // 2: random ack/response stalls
        quiet_mem(1, 5);
        data_mode = 1;
        w0 = wen_cnt;
        d0 = done_cnt;
        for (int k = 0; k < 20; k++) begin
            l = LW'($urandom);
            issue(l, 1'b1);
            wait_done("t2_done_timeout");
        end
        @(negedge clk);
        check("t2_wen_count",  128'(wen_cnt - w0),  128'd20);
        check("t2_done_count", 128'(done_cnt - d0), 128'd20);

        // 3: abort after 2 acks and 1 response, then drain the second response
        wait_idle();
        quiet_mem(0, 0);
        data_mode = 1;
        w0 = wen_cnt;
        d0 = done_cnt;
        push_addrs(12'h00A, 2);
        issue(12'h00A, 1'b0);
        @(posedge clk); #1; bus.fill_abort = 1'b1;   // sampled at c2
        @(posedge clk); #1; bus.fill_abort = 1'b0;
        @(negedge clk);
        check("t3_drain_busy", {127'd0, bus.fill_busy}, 128'd1);
        check("t3_drain_noreq", {127'd0, bus.mem_req}, 128'd0);
        @(negedge clk);
        check("t3_idle_after_drain", {127'd0, bus.fill_busy}, 128'd0);
        repeat (3) @(negedge clk);
        check("t3_no_wen",  128'(wen_cnt - w0),  128'd0);
        check("t3_no_done", 128'(done_cnt - d0), 128'd0);
        issue(12'h006, 1'b1);
        wait_done("t3_refill_timeout");

        // 4a: abort coincides with the 4th response
        issue(12'h007, 1'b1);
        repeat (4) @(posedge clk);
        #1; bus.fill_abort = 1'b1;                   // sampled at c5
        @(posedge clk); #1; bus.fill_abort = 1'b0;
        wait_done("t4a_done_timeout");
        // 4b: abort held through WRITE and DONE
        issue(12'h008, 1'b1);
        repeat (5) @(posedge clk);
        #1; bus.fill_abort = 1'b1;
        wait_done("t4b_done_timeout");
        bus.fill_abort = 1'b0;

        // 5: stray rvalid, fill_req held high, back-to-back fills
        wait_idle();
        spur_en = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_spur_idle", {127'd0, bus.fill_busy}, 128'd0);
        bus.fill_ladr = 12'h009;
        bus.fill_req  = 1'b1;
        push_fill(12'h009);
        for (int k = 0; k < 3; k++) begin
            wait_done("t5_done_timeout");
            if (k < 2) begin
                bus.fill_ladr = LW'(12'h00A + k);
                push_fill(LW'(12'h00A + k));
            end else begin
                bus.fill_req = 1'b0;
            end
            @(negedge clk);
            check("t5_one_idle_gap", {127'd0, bus.fill_busy}, 128'd0);
            if (k < 2) begin
                @(negedge clk);
                check("t5_req_after_gap", {127'd0, bus.mem_req}, 128'd1);
            end
        end
        repeat (3) @(negedge clk);
        check("t5_stays_idle", {127'd0, bus.fill_busy}, 128'd0);
        spur_en = 1'b0;

        // 6: reset in WAIT after 3 responses
        w0 = wen_cnt;
        push_addrs(12'h00C, 4);
        issue(12'h00C, 1'b0);
        repeat (4) @(posedge clk);                   // c4: 4th ack, 3rd response
        #1; rst = 1'b1;
        #1;
        check("t6_busy",  {127'd0, bus.fill_busy},   128'd0);
        check("t6_req",   {127'd0, bus.mem_req},     128'd0);
        check("t6_wen",   {127'd0, bus.ram_wen_all}, 128'd0);
        check("t6_done",  {127'd0, bus.fill_done},   128'd0);
        check("t6_radr",  {96'd0, bus.mem_radr},     128'd0);
        check("t6_wadr",  {116'd0, bus.ram_wadr_all}, 128'd0);
        check("t6_wdata", bus.ram_wdata_all,         128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_after_rst", {127'd0, bus.fill_busy}, 128'd0);
        check("t6_no_wen", 128'(wen_cnt - w0), 128'd0);
        issue(12'h00D, 1'b1);
        wait_done("t6_refill_timeout");

        repeat (3) @(negedge clk);
        check("end_lines_left", 128'(line_q.size()), 128'd0);
        check("end_addrs_left", 128'(addr_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
